l2_tlb_ctrl: RTL

L2_TLB_CTRL -- requirements
Module: l2_tlb_ctrl

---
 rtl/l2_tlb_ctrl_if.sv | 57 +++++
 rtl/l2_tlb_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/l2_tlb_ctrl_if.sv
// Signal bundle between the L2 TLB miss controller, the two L1 TLB requesters,
// the L2 TLB lookup port and the page-table walker.
interface l2_tlb_ctrl_if #(
    parameter int ASID_WIDTH = 1,
    parameter int VLEN       = 64,
    parameter int PTE_WIDTH  = 64
);
    logic                             flush_i;
    logic [1:0]                       req_valid_i;
    logic [1:0]                       req_ready_o;
    logic [1:0][VLEN-1:0]             req_vaddr_i;
    logic [1:0][ASID_WIDTH-1:0]       req_asid_i;
    logic                             lu_access_o;
    logic [VLEN-1:0]                  lu_vaddr_o;
    logic [ASID_WIDTH-1:0]            lu_asid_o;
    logic                             l2_hit_i;
    logic                             l2_all_checked_i;
    logic [PTE_WIDTH-1:0]             l2_pte_i;
    logic                             l2_is_2M_i;
    logic                             l2_is_1G_i;
    logic                             ptw_req_valid_o;
    logic                             ptw_req_ready_i;
    logic [VLEN-1:0]                  ptw_vaddr_o;
    logic [ASID_WIDTH-1:0]            ptw_asid_o;
    logic                             ptw_done_i;
    logic                             ptw_err_i;
    logic [PTE_WIDTH-1:0]             ptw_pte_i;
    logic                             ptw_is_2M_i;
    logic                             ptw_is_1G_i;
    logic                             resp_valid_o;
    logic                             resp_id_o;
    logic                             resp_hit_o;
    logic                             resp_err_o;
    logic [PTE_WIDTH-1:0]             resp_pte_o;
    logic                             resp_is_2M_o;
    logic                             resp_is_1G_o;

    modport slave (
        input  flush_i, req_valid_i, req_vaddr_i, req_asid_i,
               l2_hit_i, l2_all_checked_i, l2_pte_i, l2_is_2M_i, l2_is_1G_i,
               ptw_req_ready_i, ptw_done_i, ptw_err_i, ptw_pte_i, ptw_is_2M_i, ptw_is_1G_i,
        output req_ready_o, lu_access_o, lu_vaddr_o, lu_asid_o,
               ptw_req_valid_o, ptw_vaddr_o, ptw_asid_o,
               resp_valid_o, resp_id_o, resp_hit_o, resp_err_o,
               resp_pte_o, resp_is_2M_o, resp_is_1G_o
    );

    modport master (
        output flush_i, req_valid_i, req_vaddr_i, req_asid_i,
               l2_hit_i, l2_all_checked_i, l2_pte_i, l2_is_2M_i, l2_is_1G_i,
               ptw_req_ready_i, ptw_done_i, ptw_err_i, ptw_pte_i, ptw_is_2M_i, ptw_is_1G_i,
        input  req_ready_o, lu_access_o, lu_vaddr_o, lu_asid_o,
               ptw_req_valid_o, ptw_vaddr_o, ptw_asid_o,
               resp_valid_o, resp_id_o, resp_hit_o, resp_err_o,
               resp_pte_o, resp_is_2M_o, resp_is_1G_o
    );
endinterface

// File: rtl/l2_tlb_ctrl.sv
// L2 TLB miss controller: arbitrates ITLB/DTLB misses, probes the L2 TLB and
// falls back to the page-table walker, returning one response per transaction.
module l2_tlb_ctrl #(
    parameter int ASID_WIDTH = 1,
    parameter int VLEN       = 64,
    parameter int PTE_WIDTH  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    l2_tlb_ctrl_if.slave      bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        PTW_REQ  = 3'd2,
        PTW_WAIT = 3'd3,
        DRAIN    = 3'd4,
        RESP     = 3'd5
    } state_e;

    state_e                state_r, state_s;
    logic                  rr_r;
    logic [1:0]            wd_r, wd_s;
    logic [VLEN-1:0]       vaddr_r;
    logic [ASID_WIDTH-1:0] asid_r;
    logic                  id_r;
    logic [PTE_WIDTH-1:0]  pte_r;
    logic                  is_2m_r, is_1g_r, hit_r, err_r;
    logic                  grant_s, grant_id_s, lat_l2_s, lat_ptw_s;

    // Next-state, grant and latch-enable decode.
    always_comb begin
        state_s    = state_r;
        wd_s       = wd_r;
        grant_s    = 1'b0;
        grant_id_s = rr_r;
        lat_l2_s   = 1'b0;
        lat_ptw_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rst_i && !bus.flush_i && (bus.req_valid_i != 2'b00)) begin
                    grant_s    = 1'b1;
                    grant_id_s = (bus.req_valid_i == 2'b11) ? rr_r : bus.req_valid_i[1];
                    wd_s       = 2'd0;
                    state_s    = LOOKUP;
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                // The watchdog turns a lookup that never reports completion into a miss.
                if (bus.flush_i) begin
                    state_s = IDLE;
                end else if (bus.l2_all_checked_i && bus.l2_hit_i) begin
                    lat_l2_s = 1'b1;
                    state_s  = RESP;
                end else if (bus.l2_all_checked_i || (wd_r == 2'd2)) begin
                    state_s = PTW_REQ;
                end else begin
                    wd_s = wd_r + 2'd1;
                end
            end
            PTW_REQ: begin
                if (bus.flush_i) begin
                    state_s = IDLE;
                end else if (bus.ptw_req_ready_i) begin
                    state_s = PTW_WAIT;
                end else begin
                    state_s = PTW_REQ;
                end
            end
            PTW_WAIT: begin
                if (bus.ptw_done_i && bus.flush_i) begin
                    state_s = IDLE;
                end else if (bus.ptw_done_i) begin
                    lat_ptw_s = 1'b1;
                    state_s   = RESP;
                end else if (bus.flush_i) begin
                    state_s = DRAIN;
                end else begin
                    state_s = PTW_WAIT;
                end
            end
            DRAIN: begin
                if (bus.ptw_done_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, arbitration pointer and lookup watchdog registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            rr_r    <= 1'b1;
            wd_r    <= 2'd0;
        end else begin
            state_r <= state_s;
            wd_r    <= wd_s;
            if (grant_s) begin
                rr_r <= ~grant_id_s;
            end
        end
    end

    // Request payload and translation result capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vaddr_r <= '0;
            asid_r  <= '0;
            id_r    <= 1'b0;
            pte_r   <= '0;
            is_2m_r <= 1'b0;
            is_1g_r <= 1'b0;
            hit_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (grant_s) begin
                vaddr_r <= bus.req_vaddr_i[grant_id_s];
                asid_r  <= bus.req_asid_i[grant_id_s];
                id_r    <= grant_id_s;
            end
            if (lat_l2_s) begin
                pte_r   <= bus.l2_pte_i;
                is_2m_r <= bus.l2_is_2M_i;
                is_1g_r <= bus.l2_is_1G_i;
                hit_r   <= 1'b1;
                err_r   <= 1'b0;
            end else if (lat_ptw_s) begin
                pte_r   <= bus.ptw_pte_i;
                is_2m_r <= bus.ptw_is_2M_i;
                is_1g_r <= bus.ptw_is_1G_i;
                hit_r   <= 1'b0;
                err_r   <= bus.ptw_err_i;
            end
        end
    end

    // A flush in the same cycle suppresses a pending walk request or response.
    assign bus.req_ready_o     = grant_s ? (grant_id_s ? 2'b10 : 2'b01) : 2'b00;
    assign bus.lu_access_o     = (state_r == LOOKUP) && (wd_r == 2'd0);
    assign bus.lu_vaddr_o      = vaddr_r;
    assign bus.lu_asid_o       = asid_r;
    assign bus.ptw_req_valid_o = (state_r == PTW_REQ) && !bus.flush_i;
    assign bus.ptw_vaddr_o     = vaddr_r;
    assign bus.ptw_asid_o      = asid_r;
    assign bus.resp_valid_o    = (state_r == RESP) && !bus.flush_i;
    assign bus.resp_id_o       = id_r;
    assign bus.resp_hit_o      = hit_r;
    assign bus.resp_err_o      = err_r;
    assign bus.resp_pte_o      = pte_r;
    assign bus.resp_is_2M_o    = is_2m_r;
    assign bus.resp_is_1G_o    = is_1g_r;
endmodule
